// File: rtl/regfile_wb_writer.sv
// Queues register-file writebacks and issues one write per cycle (WB_FWD_EN adds a forwarding lookup).
// Latency: 2 edges from acceptance to dselect/dbus, plus 1 per stall cycle and per older entry.
// Backpressure: wr_ready drops when the FIFO is full; stall holds the queue without popping.
module regfile_wb_writer #(
  parameter int DEPTH    = 4,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [63:0]      wr_data,
  input  logic             stall,
  output logic [NREGS-1:0] dselect,
  output logic [63:0]      dbus,
  output logic             busy,
  input  logic [AW-1:0]    fwd_addr,
  output logic             fwd_hit,
  output logic [63:0]      fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] addr_q [DEPTH];
  logic [63:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign wr_ready = (count != CW'(DEPTH));
  assign busy     = (count != '0) || (dselect != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = (count != '0) && !stall;

  // Storage has no reset; occupancy is tracked solely by count.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      addr_q[tail] <= wr_addr;
      data_q[tail] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      dselect <= '0;
      dbus    <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop) begin
        head <= head + PW'(1);
        if (addr_q[head] == AW'(ZERO_REG)) begin
          dselect <= '0;
          dbus    <= '0;
        end else begin
          dselect <= NREGS'(1) << addr_q[head];
          dbus    <= data_q[head];
        end
      end else begin
        dselect <= '0;
        dbus    <= '0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef WB_FWD_EN
  // Scan oldest to youngest so the youngest match wins; the output stage is older than any queued entry.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (dselect[fwd_addr]) begin
      fwd_hit  = 1'b1;
      fwd_data = dbus;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (addr_q[head + PW'(i)] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head + PW'(i)];
      end
    end
    if (fwd_addr == AW'(ZERO_REG)) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^fwd_addr;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Directed vector bench for regfile_wb_writer; forwarding expectations apply only when WB_FWD_EN is defined.
module tb_regfile_wb_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        stall;
  logic [31:0] dselect;
  logic [63:0] dbus;
  logic        busy;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [63:0] fwd_data;

  int total  = 0;
  int passed = 0;

  regfile_wb_writer dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .stall(stall), .dselect(dselect),
    .dbus(dbus), .busy(busy), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        stall;
    logic [4:0]  faddr;
    logic        rdy;
    logic [31:0] dsel;
    logic [63:0] dbus;
    logic        busy;
    logic        fhit;
    logic [63:0] fdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic v, logic [4:0] addr, logic [63:0] data,
                              logic stl, logic [4:0] faddr, logic rdy, logic [31:0] dsel,
                              logic [63:0] db, logic bsy, logic fhit, logic [63:0] fdata);
    vec_t r;
    r.rst = rst; r.v = v; r.addr = addr; r.data = data; r.stall = stl; r.faddr = faddr;
    r.rdy = rdy; r.dsel = dsel; r.dbus = db; r.busy = bsy; r.fhit = fhit; r.fdata = fdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drive on the negedge, let one posedge occur, then settle before sampling.
  task automatic drive(input logic rst, input logic v, input logic [4:0] addr,
                       input logic [63:0] data, input logic stl, input logic [4:0] faddr);
    @(negedge clk);
    reset = rst; wr_valid = v; wr_addr = addr; wr_data = data; stall = stl; fwd_addr = faddr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] sa(int i);
    return 5'((i * 3 + 1) % 31);
  endfunction

  function automatic logic [63:0] sd(int i);
    return 64'h1000 + 64'(i);
  endfunction

  localparam logic [63:0] D = 64'hDEADBEEF_00000001;

  initial begin
    int e;
    int q[$];
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; stall = 1'b0; fwd_addr = '0;

    //                rst v  addr  data    stl faddr rdy  dsel          dbus      busy hit fdata
    vecs.push_back(mk(1, 0, 5'd0,  64'h0,  0, 5'd0,  1, 32'h0,        64'h0,     0, 0, 64'h0));
    // single write
    vecs.push_back(mk(0, 1, 5'd5,  D,      0, 5'd5,  1, 32'h0,        64'h0,     1, 1, D));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd5,  1, 32'h0000_0020, D,        1, 1, D));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd5,  1, 32'h0,        64'h0,     0, 0, 64'h0));
    // fill under stall, fifth held, then drain
    vecs.push_back(mk(0, 1, 5'd1,  64'h1,  1, 5'd0,  1, 32'h0,        64'h0,     1, 0, 64'h0));
    vecs.push_back(mk(0, 1, 5'd2,  64'h2,  1, 5'd0,  1, 32'h0,        64'h0,     1, 0, 64'h0));
    vecs.push_back(mk(0, 1, 5'd3,  64'h3,  1, 5'd0,  1, 32'h0,        64'h0,     1, 0, 64'h0));
    vecs.push_back(mk(0, 1, 5'd4,  64'h4,  1, 5'd0,  0, 32'h0,        64'h0,     1, 0, 64'h0));
    vecs.push_back(mk(0, 1, 5'd6,  64'h6,  1, 5'd6,  0, 32'h0,        64'h0,     1, 0, 64'h0));
    vecs.push_back(mk(0, 1, 5'd6,  64'h6,  0, 5'd6,  1, 32'h0000_0002, 64'h1,    1, 0, 64'h0));
    vecs.push_back(mk(0, 1, 5'd6,  64'h6,  0, 5'd6,  1, 32'h0000_0004, 64'h2,    1, 1, 64'h6));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd6,  1, 32'h0000_0008, 64'h3,    1, 1, 64'h6));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd6,  1, 32'h0000_0010, 64'h4,    1, 1, 64'h6));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd6,  1, 32'h0000_0040, 64'h6,    1, 1, 64'h6));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd6,  1, 32'h0,        64'h0,     0, 0, 64'h0));
    // zero-register drop
    vecs.push_back(mk(0, 1, 5'd31, 64'h1234, 0, 5'd31, 1, 32'h0,      64'h0,     1, 0, 64'h0));
    vecs.push_back(mk(0, 1, 5'd0,  64'h55, 0, 5'd31, 1, 32'h0,        64'h0,     1, 0, 64'h0));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd0,  1, 32'h0000_0001, 64'h55,   1, 1, 64'h55));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd0,  1, 32'h0,        64'h0,     0, 0, 64'h0));
    // forwarding priority
    vecs.push_back(mk(0, 1, 5'd7,  64'hA,  1, 5'd7,  1, 32'h0,        64'h0,     1, 1, 64'hA));
    vecs.push_back(mk(0, 1, 5'd7,  64'hB,  1, 5'd7,  1, 32'h0,        64'h0,     1, 1, 64'hB));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  1, 5'd31, 1, 32'h0,        64'h0,     1, 0, 64'h0));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd7,  1, 32'h0000_0080, 64'hA,    1, 1, 64'hB));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd7,  1, 32'h0000_0080, 64'hB,    1, 1, 64'hB));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd7,  1, 32'h0,        64'h0,     0, 0, 64'h0));
    // reset mid-queue discards pending writes and overrides a push
    vecs.push_back(mk(0, 1, 5'd9,  64'h9,  1, 5'd9,  1, 32'h0,        64'h0,     1, 1, 64'h9));
    vecs.push_back(mk(0, 1, 5'd10, 64'h10, 1, 5'd9,  1, 32'h0,        64'h0,     1, 1, 64'h9));
    vecs.push_back(mk(0, 1, 5'd11, 64'h11, 1, 5'd9,  1, 32'h0,        64'h0,     1, 1, 64'h9));
    vecs.push_back(mk(1, 1, 5'd12, 64'h12, 1, 5'd9,  1, 32'h0,        64'h0,     0, 0, 64'h0));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd9,  1, 32'h0,        64'h0,     0, 0, 64'h0));
    vecs.push_back(mk(0, 0, 5'd0,  64'h0,  0, 5'd12, 1, 32'h0,        64'h0,     0, 0, 64'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      logic        eh;
      logic [63:0] ed;
      drive(vecs[i].rst, vecs[i].v, vecs[i].addr, vecs[i].data, vecs[i].stall, vecs[i].faddr);
`ifdef WB_FWD_EN
      eh = vecs[i].fhit; ed = vecs[i].fdata;
`else
      eh = 1'b0; ed = 64'h0;
`endif
      chk($sformatf("v%0d wr_ready", i), 64'(wr_ready), 64'(vecs[i].rdy));
      chk($sformatf("v%0d dselect", i), 64'(dselect), 64'(vecs[i].dsel));
      chk($sformatf("v%0d dbus", i), dbus, vecs[i].dbus);
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].busy));
      chk($sformatf("v%0d fwd_hit", i), 64'(fwd_hit), 64'(eh));
      chk($sformatf("v%0d fwd_data", i), fwd_data, ed);
    end

    // Steady state: two entries queued, then push+pop every cycle across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, sa(i), sd(i), 1'b1, 5'd0);
      q.push_back(i);
      chk($sformatf("ss prefill%0d dselect", i), 64'(dselect), 64'h0);
    end
    for (int i = 2; i < 10; i++) begin
      drive(1'b0, 1'b1, sa(i), sd(i), 1'b0, 5'd0);
      e = q.pop_front();
      q.push_back(i);
      chk($sformatf("ss%0d dselect", i), 64'(dselect), 64'(32'h1 << sa(e)));
      chk($sformatf("ss%0d dbus", i), dbus, sd(e));
      chk($sformatf("ss%0d wr_ready", i), 64'(wr_ready), 64'h1);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
      e = q.pop_front();
      chk($sformatf("ss drain%0d dselect", i), 64'(dselect), 64'(32'h1 << sa(e)));
      chk($sformatf("ss drain%0d dbus", i), dbus, sd(e));
    end
    drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    chk("ss idle busy", 64'(busy), 64'h0);
    chk("ss idle dselect", 64'(dselect), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_writer.md
Name: regfile_wb_writer

Overview:
- Write-side driver for the 32-entry 64-bit register file.
- Queues writeback requests from the datapath in a small FIFO and issues one write per cycle: a one-hot register select plus the 64-bit write data.
- Select and data are registered on posedge clk, so both are stable when the register cells capture on the following negedge.
- Optionally exposes a forwarding lookup for values that are queued but not yet written.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- NREGS, 32, number of registers; width of the dselect bus.
- AW, 5, register address width; NREGS = 2**AW.
- ZERO_REG, 31, address of the hardwired-zero register; writes to it are dropped.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  writeback request present.
- wr_ready  out  1  FIFO can accept a request; equals (count != DEPTH).
- wr_addr  in  AW  destination register.
- wr_data  in  64  value to write.
- stall  in  1  when high, no entry is popped this cycle.
- dselect  out  NREGS  one-hot write select to the register file; all zero means no write.
- dbus  out  64  write data to the register file.
- busy  out  1  high if count != 0 or dselect != 0.
- fwd_addr  in  AW  forwarding lookup address (feature only).
- fwd_hit  out  1  a pending write to fwd_addr exists (feature only).
- fwd_data  out  64  youngest pending value for fwd_addr (feature only).

Behaviour:
- Reset: head, tail and count cleared to 0; dselect=0; dbus=0; busy=0; FIFO contents don't-care. Reset overrides a push or pop in the same cycle. Reset asserted mid-queue discards all pending writes.
- Push: occurs on a posedge with wr_valid && wr_ready. The entry is written at tail, tail increments mod DEPTH, count increments.
- Pop: occurs on a posedge with count != 0 && !stall, using the head entry.
  - Normal address: dselect <= 1 << addr; dbus <= data.
  - addr == ZERO_REG: dselect <= 0; dbus <= 0. The entry is still consumed.
  - head increments mod DEPTH; count decrements.
- No pop (empty or stall): dselect <= 0; dbus <= 0. Output is a single-cycle pulse per write and is never held.
- Push and pop in the same edge: count is unchanged and both pointers advance.
- Full: wr_ready is low, so a push is refused even if a pop happens that edge. There is no same-cycle pass-through.
- Empty: a push into an empty FIFO cannot pop on the same edge.
- Latency: request accepted at edge k, popped at edge k+1, dselect/dbus valid during cycle k+1 to k+2, register captures at the negedge inside that cycle. Minimum 2 edges, plus 1 per stall cycle and per older entry.
- Ordering: strict FIFO; writes to the same register retire in acceptance order.
- Throughput: one write per cycle sustained while !stall.
- wr_ready and busy are combinational from registered state only; no combinational path from wr_valid.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: fwd_hit and fwd_data are combinational and search all valid FIFO entries plus the currently issuing output stage (dselect != 0).
  - Priority, youngest first: FIFO entries nearest tail, then the output stage.
  - fwd_addr == ZERO_REG never hits; fwd_data=0 when there is no hit.
- Not defined: fwd_hit tied 0, fwd_data tied 0, fwd_addr ignored, no comparator logic synthesised.

Test Plan:
- Reset then single write: push addr=5, data=64'hDEADBEEF_00000001 at edge 1 → at edge 2 dselect=32'h0000_0020, dbus=64'hDEADBEEF_00000001 for exactly one cycle, then both return to 0 and busy=0.
- Fill to full with stall=1: four pushes to addr 1..4 → wr_ready=0 and a fifth request is held. Release stall → dselect pulses 0x2, 0x4, 0x8, 0x10 on consecutive cycles, then the fifth request issues.
- Zero-register drop: push addr=31, data=64'h1234, then addr=0, data=64'h55 → first pop gives dselect=0; next cycle dselect=32'h1, dbus=64'h55.
- Simultaneous push/pop at steady state: count=2, one push and one pop per cycle for 8 cycles → count stays 2, pointer wrap is correct, output order matches input order.
- Reset mid-operation: 3 entries queued with stall=1, assert reset for 1 cycle → dselect=0, count=0, wr_ready=1, no queued write ever issues.
- WB_FWD_EN: queue addr=7 with 64'hA then addr=7 with 64'hB, fwd_addr=7 → fwd_hit=1, fwd_data=64'hB. After both retire → fwd_hit=0. With fwd_addr=31 → fwd_hit=0.
